// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Stall/flush sequencer for the 5-stage pipeline. It detects load-use
//   hazards between ID and EX, squashes wrong-path instructions after a
//   redirect (taken branch / jump resolved in EX), and freezes the whole
//   pipeline while data memory is busy. Two saturating counters record stall
//   cycles and accepted redirects for performance debug.
//
//   Control outputs are combinational from the state and the current inputs.
//   While rst_i is high they are forced to the reset pattern.
//
// Parameters
//   FLUSH_CYCLES  bubble cycles per redirect (>=1); >1 uses the FLUSH state
//   CNT_W         width of the perf counters
//
// Ports
//   clk_i, rst_i           clock (rising edge), async active-high reset
//   id_rs1_i, id_rs2_i     source registers of the instruction in ID
//   id_use_rs1_i/_rs2_i    ID instruction actually reads rs1 / rs2
//   ex_memread_i, ex_rd_i  instruction in EX is a load, and its rd
//   redirect_i             taken branch or jump resolved in EX
//   dmem_req_i/_ready_i    MEM stage access request / completion
//   cnt_clr_i              synchronous clear of the perf counters
//   pc_write_o             PC may update
//   ifid_write_o           IF/ID may load
//   ifid_flush_o           IF/ID loads a NOP
//   idex_flush_o           ID/EX loads a bubble
//   freeze_o               every pipeline register holds (memory wait)
//   stall_cnt_o            cycles with pc_write_o low (saturating)
//   flush_cnt_o            accepted redirects (saturating)
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             redirect_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ready_i,
  input  logic             cnt_clr_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             freeze_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // Remaining-bubble counter only needs to hold FLUSH_CYCLES-1.
  localparam int FCW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0]   FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  // Which rule set governs this cycle. The MEM_WAIT release cycle behaves
  // exactly like the state that was interrupted by the memory wait.
  typedef enum logic [1:0] {
    EV_RUN   = 2'd0,
    EV_FLUSH = 2'd1,
    EV_HOLD  = 2'd2,
    EV_BAD   = 2'd3
  } eval_t;

  state_t          state_r, state_nxt_s;
  eval_t           eval_s;
  logic [FCW-1:0]  fcnt_r, fcnt_nxt_s;
  logic            ret_flush_r, ret_flush_nxt_s;
  logic            memw_s, lu_s, redirect_acc_s;
  logic            pc_write_s, ifid_write_s, ifid_flush_s, idex_flush_s, freeze_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1'b1);
    end
  endfunction

  // Hazard terms: memory stall and load-use dependency (x0 never hazards).
  always_comb begin
    memw_s = dmem_req_i & ~dmem_ready_i;
    lu_s   = ex_memread_i & (ex_rd_i != 5'd0) &
             ((id_use_rs1_i & (ex_rd_i == id_rs1_i)) |
              (id_use_rs2_i & (ex_rd_i == id_rs2_i)));
  end

  // Next-state and control-output decode.
  always_comb begin
    pc_write_s      = 1'b1;
    ifid_write_s    = 1'b1;
    ifid_flush_s    = 1'b0;
    idex_flush_s    = 1'b0;
    freeze_s        = 1'b0;
    redirect_acc_s  = 1'b0;
    state_nxt_s     = state_r;
    fcnt_nxt_s      = fcnt_r;
    ret_flush_nxt_s = ret_flush_r;
    eval_s          = EV_BAD;

    case (state_r)
      RUN:      eval_s = EV_RUN;
      FLUSH:    eval_s = EV_FLUSH;
      MEM_WAIT: begin
        if (!dmem_ready_i) begin
          eval_s = EV_HOLD;
        end else if (ret_flush_r) begin
          eval_s = EV_FLUSH;
        end else begin
          eval_s = EV_RUN;
        end
      end
      default:  eval_s = EV_BAD;
    endcase

    case (eval_s)
      EV_RUN: begin
        if (memw_s) begin
          freeze_s        = 1'b1;
          pc_write_s      = 1'b0;
          ifid_write_s    = 1'b0;
          state_nxt_s     = MEM_WAIT;
          ret_flush_nxt_s = 1'b0;
        end else if (redirect_i) begin
          // Redirect outranks load-use: the dependent instruction is squashed.
          ifid_flush_s   = 1'b1;
          idex_flush_s   = 1'b1;
          redirect_acc_s = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt_s = FLUSH;
            fcnt_nxt_s  = FLUSH_LOAD;
          end else begin
            state_nxt_s = RUN;
          end
        end else if (lu_s) begin
          pc_write_s   = 1'b0;
          ifid_write_s = 1'b0;
          idex_flush_s = 1'b1;
          state_nxt_s  = RUN;
        end else begin
          state_nxt_s = RUN;
        end
      end
      EV_FLUSH: begin
        if (memw_s) begin
          // Bubble count is frozen; resume FLUSH once memory completes.
          freeze_s        = 1'b1;
          pc_write_s      = 1'b0;
          ifid_write_s    = 1'b0;
          state_nxt_s     = MEM_WAIT;
          ret_flush_nxt_s = 1'b1;
        end else if (redirect_i) begin
          ifid_flush_s   = 1'b1;
          redirect_acc_s = 1'b1;
          state_nxt_s    = FLUSH;
          fcnt_nxt_s     = FLUSH_LOAD;
        end else begin
          ifid_flush_s = 1'b1;
          if (fcnt_r <= FCW'(1'b1)) begin
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = FLUSH;
            fcnt_nxt_s  = fcnt_r - FCW'(1'b1);
          end
        end
      end
      EV_HOLD: begin
        freeze_s     = 1'b1;
        pc_write_s   = 1'b0;
        ifid_write_s = 1'b0;
        state_nxt_s  = MEM_WAIT;
      end
      default: begin
        // Illegal state: squash the pipe front-end and recover to RUN.
        pc_write_s      = 1'b0;
        ifid_write_s    = 1'b0;
        ifid_flush_s    = 1'b1;
        idex_flush_s    = 1'b1;
        state_nxt_s     = RUN;
        ret_flush_nxt_s = 1'b0;
      end
    endcase

    if (rst_i) begin
      pc_write_s     = 1'b0;
      ifid_write_s   = 1'b0;
      ifid_flush_s   = 1'b1;
      idex_flush_s   = 1'b1;
      freeze_s       = 1'b0;
      redirect_acc_s = 1'b0;
    end else begin
      redirect_acc_s = redirect_acc_s;
    end
  end

  // State, bubble counter and FLUSH-resume flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= RUN;
      fcnt_r      <= {FCW{1'b0}};
      ret_flush_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fcnt_r      <= fcnt_nxt_s;
      ret_flush_r <= ret_flush_nxt_s;
    end
  end

  // Saturating perf counters; clear beats increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_i) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_write_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (redirect_acc_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign pc_write_o   = pc_write_s;
  assign ifid_write_o = ifid_write_s;
  assign ifid_flush_o = ifid_flush_s;
  assign idex_flush_o = idex_flush_s;
  assign freeze_o     = freeze_s;
  assign stall_cnt_o  = stall_cnt_r;
  assign flush_cnt_o  = flush_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances: A (FLUSH_CYCLES=1, CNT_W=16)
// and B (FLUSH_CYCLES=3, CNT_W=4). Shared data inputs, separate resets; the
// instance not under test is held in reset. Directed vectors push their
// hand-computed expectations into a queue; a monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic [4:0] rs1 = 5'd0, rs2 = 5'd0, exrd = 5'd0;
  logic       use1 = 1'b0, use2 = 1'b0, memread = 1'b0;
  logic       redir = 1'b0, req = 1'b0, ready = 1'b0, clr = 1'b0;

  logic        pw_a, iw_a, ifl_a, idl_a, frz_a;
  logic [15:0] sc_a, fc_a;
  logic        pw_b, iw_b, ifl_b, idl_b, frz_b;
  logic [3:0]  sc_b, fc_b;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst_a),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .ex_memread_i(memread), .ex_rd_i(exrd), .redirect_i(redir),
    .dmem_req_i(req), .dmem_ready_i(ready), .cnt_clr_i(clr),
    .pc_write_o(pw_a), .ifid_write_o(iw_a), .ifid_flush_o(ifl_a),
    .idex_flush_o(idl_a), .freeze_o(frz_a),
    .stall_cnt_o(sc_a), .flush_cnt_o(fc_a)
  );

  pipe_hazard_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst_b),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_use_rs1_i(use1), .id_use_rs2_i(use2),
    .ex_memread_i(memread), .ex_rd_i(exrd), .redirect_i(redir),
    .dmem_req_i(req), .dmem_ready_i(ready), .cnt_clr_i(clr),
    .pc_write_o(pw_b), .ifid_write_o(iw_b), .ifid_flush_o(ifl_b),
    .idex_flush_o(idl_b), .freeze_o(frz_b),
    .stall_cnt_o(sc_b), .flush_cnt_o(fc_b)
  );

  // Expected {pc_write, ifid_write, ifid_flush, idex_flush, freeze}
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] RST  = 5'b00110;
  localparam logic [4:0] LU   = 5'b00010;
  localparam logic [4:0] RED  = 5'b11110;
  localparam logic [4:0] FRZ  = 5'b00001;
  localparam logic [4:0] FL   = 5'b11100;
  localparam logic       A = 1'b0;
  localparam logic       B = 1'b1;

  typedef struct {
    logic       sel;
    logic [4:0] e;
    int         sc;
    int         fc;
    int         id;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   vec_id = 0;

  // Current inputs already set; record expectation, then advance a cycle.
  task automatic tick(input logic sel, input logic [4:0] e, input int sc, input int fc);
    exp_t x;
    x.sel = sel; x.e = e; x.sc = sc; x.fc = fc; x.id = vec_id;
    vec_id++;
    sb_q.push_back(x);
    @(negedge clk);
  endtask

  logic [4:0] got_e;
  int         got_sc, got_fc;
  exp_t       cur;

  // Monitor: sample mid-cycle after each falling edge.
  always @(negedge clk) begin
    #2;
    if (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      if (cur.sel == B) begin
        got_e  = {pw_b, iw_b, ifl_b, idl_b, frz_b};
        got_sc = int'(sc_b);
        got_fc = int'(fc_b);
      end else begin
        got_e  = {pw_a, iw_a, ifl_a, idl_a, frz_a};
        got_sc = int'(sc_a);
        got_fc = int'(fc_a);
      end
      n_vec++;
      if (got_e !== cur.e || got_sc != cur.sc || got_fc != cur.fc) begin
        n_err++;
        $display("FAIL vec%0d dut_%s: got ctl=%b stall=%0d flush=%0d, want ctl=%b stall=%0d flush=%0d",
                 cur.id, (cur.sel == B) ? "b" : "a", got_e, got_sc, got_fc,
                 cur.e, cur.sc, cur.fc);
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset values on both instances
    tick(A, RST, 0, 0);
    tick(B, RST, 0, 0);

    // ---------------- instance A ----------------
    rst_a = 1'b0;
    tick(A, NORM, 0, 0);
    // load-use on rs1: one bubble
    memread = 1'b1; exrd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
    tick(A, LU, 0, 0);
    memread = 1'b0;
    tick(A, NORM, 1, 0);
    // back-to-back load-use
    memread = 1'b1;
    tick(A, LU, 1, 0);
    tick(A, LU, 2, 0);
    // rd = x0 never hazards
    exrd = 5'd0; rs1 = 5'd0;
    tick(A, NORM, 3, 0);
    // rs1 not used
    exrd = 5'd5; rs1 = 5'd5; use1 = 1'b0;
    tick(A, NORM, 3, 0);
    // hazard through rs2
    rs2 = 5'd5; use2 = 1'b1;
    tick(A, LU, 3, 0);
    // registers differ
    rs2 = 5'd6;
    tick(A, NORM, 4, 0);
    // redirect outranks load-use
    use2 = 1'b0; use1 = 1'b1; redir = 1'b1;
    tick(A, RED, 4, 0);
    redir = 1'b0; memread = 1'b0;
    tick(A, NORM, 4, 1);
    // memory wait 3 cycles with redirect held, then release
    req = 1'b1; ready = 1'b0; redir = 1'b1;
    tick(A, FRZ, 4, 1);
    tick(A, FRZ, 5, 1);
    tick(A, FRZ, 6, 1);
    ready = 1'b1;
    tick(A, RED, 7, 1);
    redir = 1'b0; req = 1'b0; ready = 1'b0;
    tick(A, NORM, 7, 2);
    // clear wins over a same-cycle stall increment
    clr = 1'b1; memread = 1'b1;
    tick(A, LU, 7, 2);
    clr = 1'b0; memread = 1'b0;
    tick(A, NORM, 0, 0);

    // ---------------- instance B ----------------
    rst_a = 1'b1; rst_b = 1'b0;
    tick(B, NORM, 0, 0);
    // redirect, then 2-cycle memory wait inside FLUSH
    redir = 1'b1;
    tick(B, RED, 0, 0);
    redir = 1'b0; req = 1'b1; ready = 1'b0;
    tick(B, FRZ, 0, 1);
    tick(B, FRZ, 1, 1);
    ready = 1'b1;
    tick(B, FL, 2, 1);
    req = 1'b0; ready = 1'b0;
    tick(B, FL, 2, 1);
    tick(B, NORM, 2, 1);
    // redirect inside FLUSH restarts the bubble count
    redir = 1'b1;
    tick(B, RED, 2, 1);
    tick(B, FL, 2, 2);
    redir = 1'b0;
    tick(B, FL, 2, 3);
    tick(B, FL, 2, 3);
    tick(B, NORM, 2, 3);
    // reset pulse during MEM_WAIT
    req = 1'b1; ready = 1'b0;
    tick(B, FRZ, 2, 3);
    tick(B, FRZ, 3, 3);
    rst_b = 1'b1;
    tick(B, RST, 0, 0);
    rst_b = 1'b0; req = 1'b0;
    tick(B, NORM, 0, 0);
    // 20 consecutive stalls saturate the 4-bit counter at 15
    memread = 1'b1; exrd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(B, LU, (i > 15) ? 15 : i, 0);
    end
    memread = 1'b0;
    tick(B, NORM, 15, 0);
    // reset pulse during FLUSH
    redir = 1'b1;
    tick(B, RED, 15, 0);
    redir = 1'b0; rst_b = 1'b1;
    tick(B, RST, 0, 0);
    rst_b = 1'b0;
    tick(B, NORM, 0, 0);

    #5;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
